// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared states, SPI command opcodes and sizing helper for the SPI memory controller
package spi_mem_pkg;
   typedef enum logic [2:0] {IDLE, CLOSE, CMD, ADDR, DATA, DONE} state_t;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   function automatic int max3(input int a, input int b, input int c);
      return a > b ? (a > c ? a : c) : (b > c ? b : c);
   endfunction
endpackage

// File: rtl/spi_mem_shifter.sv
// spi_mem_shifter: MSB-first load/shift register with down-counting bit counter
module spi_mem_shifter
   import spi_mem_pkg::*;
#(
   parameter int W      = 24,
   parameter int DATA_W = 8,
   parameter int CW     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [W-1:0]      load_val,
   input  logic [CW-1:0]     load_cnt,
   input  logic              shift,
   input  logic              sin,
   output logic              msb,
   output logic [DATA_W-1:0] data,
   output logic              last
);
   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      sh_d  = load ? load_val : shift ? {sh_q[W-2:0], sin} : sh_q;
      cnt_d = load ? load_cnt : shift ? cnt_q - CW'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end
   assign msb  = sh_q[W-1];
   assign data = sh_q[DATA_W-1:0];
   assign last = cnt_q == '0;
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: multi-device SPI memory access FSM with read-stream continuation and hold
module spi_mem_ctrl
   import spi_mem_pkg::*;
#(
   parameter int N_CS   = 2,
   parameter int ADDR_W = 24,
   parameter int DATA_W = 8,
   parameter int STREAM = 1,
   localparam int DW    = N_CS > 1 ? $clog2(N_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [DW-1:0]     req_dev,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              spi_mosi,
   input  logic [N_CS-1:0]   spi_miso,
   output logic [N_CS-1:0]   spi_cs_n,
   output logic [N_CS-1:0]   spi_hold_n
);
   localparam int W  = max3(8, ADDR_W, DATA_W);
   localparam int CW = $clog2(W);
   state_t              state_q, state_d;
   logic                we_q, we_d, open_q, open_d, act;
   logic [DW-1:0]       dev_q, dev_d, open_dev_q, open_dev_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, next_q, next_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, sh_data;
   logic [N_CS-1:0]     cs_n_q, cs_n_d, hold_n_q, hold_n_d;
   logic                ld, shift, sh_msb, last, cont;
   logic [W-1:0]        ld_val;
   logic [CW-1:0]       ld_cnt;
   spi_mem_shifter #(.W(W), .DATA_W(DATA_W), .CW(CW)) u_shifter (
      .clk(clk), .rst_n(rst_n), .load(ld), .load_val(ld_val), .load_cnt(ld_cnt),
      .shift(shift), .sin(spi_miso[dev_q]), .msb(sh_msb), .data(sh_data), .last(last)
   );
   assign cont = open_q && req_dev == open_dev_q && !req_we && req_addr == next_q;
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      dev_d      = dev_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      open_d     = open_q;
      open_dev_d = open_dev_q;
      next_d     = next_q;
      ld         = 1'b0;
      ld_val     = '0;
      ld_cnt     = '0;
      shift      = 1'b0;
      if (state_q == IDLE && req_valid) begin
         we_d    = req_we;
         dev_d   = req_dev;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         if (cont) begin
            state_d = DATA;
            ld      = 1'b1;
            ld_cnt  = CW'(DATA_W - 1);
         end else if (open_q && req_dev == open_dev_q) begin
            state_d = CLOSE;
            open_d  = 1'b0;
         end else begin
            state_d = CMD;
            ld      = 1'b1;
            ld_val  = W'(req_we ? CMD_WRITE : CMD_READ) << (W - 8);
            ld_cnt  = CW'(7);
         end
      end else if (state_q == CLOSE) begin
         state_d = CMD;
         ld      = 1'b1;
         ld_val  = W'(we_q ? CMD_WRITE : CMD_READ) << (W - 8);
         ld_cnt  = CW'(7);
      end else if (state_q == CMD || state_q == ADDR || state_q == DATA) begin
         shift = 1'b1;
         if (last) begin
            state_d = state_q == CMD ? ADDR : state_q == ADDR ? DATA : DONE;
            ld      = state_q != DATA;
            ld_val  = state_q == CMD ? W'(addr_q) << (W - ADDR_W) :
                      we_q ? W'(wdata_q) << (W - DATA_W) : '0;
            ld_cnt  = state_q == CMD ? CW'(ADDR_W - 1) : CW'(DATA_W - 1);
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
         // a finished read becomes the single open stream, replacing any held one
         if (!we_q && STREAM != 0) begin
            open_d     = 1'b1;
            open_dev_d = dev_q;
            next_d     = addr_q + ADDR_W'(DATA_W / 8);
         end
      end
      act = state_d != IDLE && state_d != CLOSE;
      for (int i = 0; i < N_CS; i++) begin
         cs_n_d[i]   = !((act && dev_d == DW'(i)) || (open_d && open_dev_d == DW'(i)));
         hold_n_d[i] = !(act && open_d && open_dev_d == DW'(i) && dev_d != open_dev_d);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         dev_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         open_q     <= 1'b0;
         open_dev_q <= '0;
         next_q     <= '0;
         cs_n_q     <= '1;
         hold_n_q   <= '1;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         dev_q      <= dev_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         open_q     <= open_d;
         open_dev_q <= open_dev_d;
         next_q     <= next_d;
         cs_n_q     <= cs_n_d;
         hold_n_q   <= hold_n_d;
      end
   end
   assign req_ready  = state_q == IDLE;
   assign rsp_valid  = state_q == DONE;
   assign rsp_rdata  = (state_q == DONE && !we_q) ? sh_data : '0;
   assign spi_mosi   = sh_msb && (state_q == CMD || state_q == ADDR || (state_q == DATA && we_q));
   assign spi_cs_n   = cs_n_q;
   assign spi_hold_n = hold_n_q;
endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter N_CS, default 2: number of SPI devices sharing spi_mosi; each has its own cs_n, hold_n and miso.
REQ-002 Parameter ADDR_W, default 24: address bits sent per command, MSB first.
REQ-003 Parameter DATA_W, default 8: data bits per transfer; SHALL be a multiple of 8, range 8..32.
REQ-004 Parameter STREAM, default 1: 1 keeps a read stream open (cs_n low) between requests.
REQ-005 Ports: clk in 1, the single clock, also the SPI bit clock; rst_n in 1, synchronous reset, active-low.
REQ-006 Ports: req_valid in 1, request offered; req_ready out 1, controller accepts; req_we in 1, 1=write 0=read.
REQ-007 Ports: req_dev in $clog2(N_CS) (min 1), target device index; req_addr in ADDR_W; req_wdata in DATA_W.
REQ-008 Ports: rsp_valid out 1, one-cycle completion pulse; rsp_rdata out DATA_W, read data, 0 for writes.
REQ-009 Ports: spi_mosi out 1; spi_miso in N_CS; spi_cs_n out N_CS; spi_hold_n out N_CS.

Function
REQ-010 States: IDLE, CLOSE, CMD, ADDR, DATA, DONE; the bit counter is sized for max(8, ADDR_W, DATA_W).
REQ-011 req_ready SHALL be 1 only in IDLE; accept occurs on an edge with req_valid && req_ready (call it cycle T).
REQ-012 Full access: CMD during T+1..T+8, sending 8'h03 (read) or 8'h02 (write) MSB first on spi_mosi; target cs_n low from T+1.
REQ-013 ADDR follows for ADDR_W cycles (T+9..T+8+ADDR_W), req_addr MSB first.
REQ-014 DATA follows for DATA_W cycles; write drives req_wdata MSB first; read samples spi_miso[req_dev] at each edge, MSB first.
REQ-015 DONE lasts 1 cycle with rsp_valid=1 and rsp_rdata valid; then IDLE. Full read at defaults: rsp_valid at T+41.
REQ-016 After a read with STREAM=1, the device stays open: cs_n low, next_addr = addr + DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-017 Continuation: a read to the open device with req_addr == next_addr SHALL go straight to DATA at T+1; rsp_valid at T+DATA_W+1.
REQ-018 Any other request to the open device, or a write to it, SHALL enter CLOSE: cs_n high exactly 1 cycle, then a full access.
REQ-019 A request to a different device while a stream is open SHALL set the open device's hold_n low and keep its cs_n low.
REQ-020 The hold condition of REQ-019 SHALL last from T+1 through DONE; that device's hold_n returns high in the following IDLE cycle.
REQ-021 A continuation of a held stream releases hold_n at T+1; the continuation check still applies after intervening accesses.
REQ-022 Writes never leave a stream open; after a write the written device's cs_n goes high in IDLE.
REQ-023 At most one device is open and at most one device is active; cs_n is low only for the active or open device.
REQ-024 spi_mosi SHALL be 0 outside CMD, ADDR and write DATA; request inputs are latched at accept and ignored afterwards.

Reset
REQ-025 When rst_n=0 at an edge, regardless of state, the next cycle SHALL show:
  - IDLE, with any open stream discarded;
  - spi_cs_n and spi_hold_n all ones;
  - spi_mosi=0, rsp_valid=0, rsp_rdata=0, req_ready=1 once rst_n=1.
REQ-026 A reset mid-transfer SHALL produce no rsp_valid for the aborted request.

Structure
REQ-027 Package spi_mem_pkg SHALL hold the state enum, CMD_READ=8'h03 and CMD_WRITE=8'h02.
REQ-028 Sub-module spi_mem_shifter SHALL implement the load/shift-out/shift-in register and bit counter; the FSM and stream tracking stay in spi_mem_ctrl.

Verification (N_CS=2, ADDR_W=24, DATA_W=8)
REQ-029 Reset released: cs_n=2'b11, hold_n=2'b11, mosi=0, req_ready=1, rsp_valid never pulses.
REQ-030 Read dev0 at 0x000010, miso[0] serialising 0xA5 in DATA:
  - cs_n[0]=0 from T+1;
  - mosi 00000011, then the 24 address bits;
  - rsp_valid at T+41 with rdata=0xA5.
REQ-031 Then read dev0 at 0x000011 with miso 0x3C: no CMD or ADDR; rsp_valid at T+9 with rdata=0x3C; cs_n[0] never high.
REQ-032 Open dev0, then write 0x5A to dev1 at 0x000100:
  - hold_n[0]=0 and cs_n[0]=0 throughout;
  - dev1 sees 0x02, the address, then 0x5A;
  - cs_n[1] high after DONE; hold_n[0]=1 in the next IDLE.
REQ-033 Open dev0 at next_addr 0x000011, then read dev0 at 0x000040: cs_n[0] high exactly 1 cycle, then a full 41-cycle read.
REQ-034 rst_n=0 during ADDR: next cycle cs_n=2'b11, mosi=0, IDLE; no rsp_valid; a following read to 0x000011 does a full access.
